// File: rtl/dcache_mem_responder.sv
// Backing-memory responder for the D-cache line-fill/writeback port.
// One request at a time, fixed access latency, one-cycle response pulse.
module dcache_mem_responder #(
    parameter int ADDR_W      = 32,
    parameter int LINE_W      = 128,
    parameter int DEPTH_LINES = 256,
    parameter int LATENCY     = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_req_valid,
    input  logic              mem_req_rw,
    input  logic [ADDR_W-1:0] mem_req_addr,
    input  logic [LINE_W-1:0] mem_req_wdata,
    output logic              mem_req_ready,
    output logic              mem_resp_valid,
    output logic [LINE_W-1:0] mem_resp_rdata,
    output logic              mem_busy
);

    localparam int IDX_W = $clog2(DEPTH_LINES);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rw_q, rw_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LINE_W-1:0]  wdata_q, wdata_d;
    logic [LINE_W-1:0]  rdata_q, rdata_d;
    logic [LINE_W-1:0]  mem_q [DEPTH_LINES];

    logic accept;
    logic access;
    logic mem_we;
    logic unused_addr;

    // Offset bits and bits above the index do not select a line.
    assign unused_addr = ^mem_req_addr;

    assign accept = mem_req_valid & mem_req_ready;

    // State register and latched request/response fields.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Line array: cleared on reset, written when a write access completes.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_LINES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    // Next-state and latency counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture and line access datapath.
    always_comb begin
        rw_d    = rw_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        if (accept) begin
            rw_d    = mem_req_rw;
            idx_d   = mem_req_addr[4 +: IDX_W];
            wdata_d = mem_req_wdata;
        end
        access  = (state_q == BUSY) && (cnt_q == '0);
        mem_we  = access & rw_q;
        rdata_d = rdata_q;
        if (access) begin
            rdata_d = rw_q ? wdata_q : mem_q[idx_q];
        end
    end

    // Handshake outputs, forced low while reset is asserted.
    always_comb begin
        mem_req_ready  = reset && (state_q == IDLE);
        mem_busy       = reset && (state_q != IDLE);
        mem_resp_valid = reset && (state_q == RESP);
        mem_resp_rdata = rdata_q;
    end

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Self-checking bench for dcache_mem_responder.
// Two builds share stimulus: LATENCY=4 and LATENCY=1.
module tb_dcache_mem_responder;

    logic         clock;
    logic         reset;
    logic         valid;
    logic         rw;
    logic [31:0]  addr;
    logic [127:0] wdata;

    logic         rdy4, rv4, bsy4;
    logic [127:0] rd4;
    logic         rdy1, rv1, bsy1;
    logic [127:0] rd1;

    logic         sel;
    logic         rdy, rv, bsy;
    logic [127:0] rd;

    int errors;
    int checks;
    int cyc;

    logic [127:0] model [256];
    logic [127:0] sb [$];

    dcache_mem_responder #(
        .ADDR_W(32), .LINE_W(128), .DEPTH_LINES(256), .LATENCY(4)
    ) dut (
        .clock(clock), .reset(reset),
        .mem_req_valid(valid), .mem_req_rw(rw),
        .mem_req_addr(addr), .mem_req_wdata(wdata),
        .mem_req_ready(rdy4), .mem_resp_valid(rv4),
        .mem_resp_rdata(rd4), .mem_busy(bsy4)
    );

    dcache_mem_responder #(
        .ADDR_W(32), .LINE_W(128), .DEPTH_LINES(256), .LATENCY(1)
    ) dut1 (
        .clock(clock), .reset(reset),
        .mem_req_valid(valid), .mem_req_rw(rw),
        .mem_req_addr(addr), .mem_req_wdata(wdata),
        .mem_req_ready(rdy1), .mem_resp_valid(rv1),
        .mem_resp_rdata(rd1), .mem_busy(bsy1)
    );

    assign rdy = sel ? rdy1 : rdy4;
    assign rv  = sel ? rv1  : rv4;
    assign bsy = sel ? bsy1 : bsy4;
    assign rd  = sel ? rd1  : rd4;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic fail(input string nm, input logic [127:0] got, input logic [127:0] exp);
        errors++;
        $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model[i] = '0;
        sb.delete();
    endtask

    // Reset with a valid write presented, which must be ignored.
    task automatic test_reset();
        @(negedge clock);
        reset = 1'b0;
        valid = 1'b1;
        rw    = 1'b1;
        addr  = 32'h0000_0050;
        wdata = {4{32'h5A5A_5A5A}};
        model_clear();
        repeat (2) begin
            @(negedge clock);
            checks++;
            if (rdy !== 1'b0) fail("reset_ready", rdy, 0);
            checks++;
            if (rv !== 1'b0) fail("reset_resp_valid", rv, 0);
            checks++;
            if (bsy !== 1'b0) fail("reset_busy", bsy, 0);
        end
        checks++;
        if (rd !== 128'd0) fail("reset_rdata", rd, 0);
        reset = 1'b1;
        valid = 1'b0;
        @(negedge clock);
        checks++;
        if (rdy !== 1'b1) fail("post_reset_ready", rdy, 1);
        checks++;
        if (bsy !== 1'b0) fail("post_reset_busy", bsy, 0);
    endtask

    // One complete request/response with latency and data checks.
    task automatic do_txn(input logic r, input logic [31:0] a,
                          input logic [127:0] wd, input int lat,
                          input string nm);
        int t_acc;
        int n;
        logic [127:0] e;
        @(negedge clock);
        valid = 1'b1;
        rw    = r;
        addr  = a;
        wdata = wd;
        n = 0;
        while (!rdy && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!rdy) begin
            checks++;
            fail({nm, "_accept_timeout"}, rdy, 1);
            valid = 1'b0;
            return;
        end
        t_acc = cyc;
        if (r) begin
            model[a[11:4]] = wd;
            sb.push_back(wd);
        end else begin
            sb.push_back(model[a[11:4]]);
        end
        @(negedge clock);
        valid = 1'b0;
        addr  = 32'hFFFF_FFF0;
        checks++;
        if (rdy !== 1'b0) fail({nm, "_ready_drop"}, rdy, 0);
        n = 0;
        while (!rv && n < 50) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (!rv) begin
            fail({nm, "_resp_timeout"}, rv, 1);
            return;
        end
        if (cyc - t_acc != lat + 1)
            fail({nm, "_latency"}, cyc - t_acc, lat + 1);
        e = sb.pop_front();
        checks++;
        if (rd !== e) fail({nm, "_rdata"}, rd, e);
        @(negedge clock);
        checks++;
        if (rdy !== 1'b1) fail({nm, "_ready_return"}, rdy, 1);
        checks++;
        if (rv !== 1'b0) fail({nm, "_resp_one_cycle"}, rv, 0);
    endtask

    task automatic test_basic_read();
        do_txn(1'b0, 32'h0000_0040, '0, 4, "read_idx4");
    endtask

    task automatic test_write_read();
        do_txn(1'b1, 32'h0000_0020,
               128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 4, "write_0x20");
        do_txn(1'b0, 32'h0000_002C, '0, 4, "read_0x2C");
    endtask

    task automatic test_wrap();
        do_txn(1'b1, 32'h0000_0030, {32{4'h1}}, 4, "write_idx3");
        do_txn(1'b0, 32'h0000_1030, '0, 4, "read_wrap");
    endtask

    // Valid held high across three reads; payload advances after each accept.
    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        int acc_t [3];
        int nacc;
        int nresp;
        int n;
        logic [127:0] e;
        addrs[0] = 32'h0000_0020;
        addrs[1] = 32'h0000_0030;
        addrs[2] = 32'h0000_0040;
        nacc  = 0;
        nresp = 0;
        @(negedge clock);
        valid = 1'b1;
        rw    = 1'b0;
        addr  = addrs[0];
        n = 0;
        while ((nresp < 3) && n < 60) begin
            if (rv) begin
                e = sb.pop_front();
                nresp++;
                checks++;
                if (rd !== e) fail("b2b_rdata", rd, e);
            end
            if (valid && rdy) begin
                acc_t[nacc] = cyc;
                sb.push_back(model[addr[11:4]]);
                nacc++;
                @(negedge clock);
                n++;
                if (nacc < 3) addr = addrs[nacc];
                else valid = 1'b0;
            end else begin
                @(negedge clock);
                n++;
            end
        end
        valid = 1'b0;
        checks++;
        if (nacc != 3) fail("b2b_accepts", nacc, 3);
        checks++;
        if (nresp != 3) fail("b2b_resps", nresp, 3);
        if (nacc == 3) begin
            checks++;
            if (acc_t[1] - acc_t[0] != 6) fail("b2b_spacing01", acc_t[1] - acc_t[0], 6);
            checks++;
            if (acc_t[2] - acc_t[1] != 6) fail("b2b_spacing12", acc_t[2] - acc_t[1], 6);
        end
        repeat (8) begin
            @(negedge clock);
            checks++;
            if (rv !== 1'b0) fail("b2b_extra_resp", rv, 0);
        end
    endtask

    // Reset during BUSY of a write must drop the response and the commit.
    task automatic test_reset_mid();
        int n;
        @(negedge clock);
        valid = 1'b1;
        rw    = 1'b1;
        addr  = 32'h0000_0070;
        wdata = {32{4'hA}};
        n = 0;
        while (!rdy && n < 50) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        valid = 1'b0;
        @(negedge clock);
        checks++;
        if (bsy !== 1'b1) fail("mid_busy_before", bsy, 1);
        reset = 1'b0;
        model_clear();
        #1;
        checks++;
        if (bsy !== 1'b0) fail("mid_busy_in_reset", bsy, 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (6) begin
            @(negedge clock);
            checks++;
            if (rv !== 1'b0) fail("mid_no_resp", rv, 0);
            checks++;
            if (bsy !== 1'b0) fail("mid_busy_after", bsy, 0);
        end
        do_txn(1'b0, 32'h0000_0070, '0, 4, "mid_read_idx7");
    endtask

    // LATENCY=1 build: timing and a request held through BUSY/RESP.
    task automatic test_latency1();
        int t;
        int n;
        logic [127:0] e;
        sel = 1'b1;
        test_reset();
        do_txn(1'b0, 32'h0000_0090, '0, 1, "l1_read");
        @(negedge clock);
        valid = 1'b1;
        rw    = 1'b0;
        addr  = 32'h0000_0090;
        n = 0;
        while (!rdy && n < 50) begin
            @(negedge clock);
            n++;
        end
        t = cyc;
        sb.push_back(model[9]);
        @(negedge clock);
        rw    = 1'b1;
        wdata = {32{4'h5}};
        checks++;
        if (rdy !== 1'b0) fail("l1_busy_ready", rdy, 0);
        checks++;
        if (rv !== 1'b0) fail("l1_busy_resp", rv, 0);
        @(negedge clock);
        checks++;
        if (rv !== 1'b1) fail("l1_resp_at_t2", rv, 1);
        checks++;
        if (rdy !== 1'b0) fail("l1_resp_ready", rdy, 0);
        e = sb.pop_front();
        checks++;
        if (rd !== e) fail("l1_held_rdata", rd, e);
        @(negedge clock);
        checks++;
        if (rdy !== 1'b1) fail("l1_ready_at_t3", rdy, 1);
        checks++;
        if (cyc - t != 3) fail("l1_ready_cycle", cyc - t, 3);
        model[9] = wdata;
        sb.push_back(wdata);
        @(negedge clock);
        valid = 1'b0;
        n = 0;
        while (!rv && n < 20) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (!rv) begin
            fail("l1_held_resp_timeout", rv, 1);
        end else begin
            e = sb.pop_front();
            if (rd !== e) fail("l1_held_write_echo", rd, e);
        end
        do_txn(1'b0, 32'h0000_0098, '0, 1, "l1_read_back");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        sel    = 1'b0;
        reset  = 1'b1;
        valid  = 1'b0;
        rw     = 1'b0;
        addr   = '0;
        wdata  = '0;
        model_clear();
        test_reset();
        test_basic_read();
        test_write_read();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_latency1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcache_mem_responder.md
Name: dcache_mem_responder

Overview:
- Backing-memory responder on the memory side of the data-cache line-fill/writeback interface.
- The cache controller initiates 128-bit line reads (miss fills) and line writes (dirty evictions).
- This block accepts one request at a time, waits a programmable access latency, commits or fetches the line in its internal line array, then returns a single-cycle response.
- It is the bench/FPGA stand-in for main memory behind the direct-mapped D-cache.

Parameters:
ADDR_W, 32, byte address width of mem_req_addr.
LINE_W, 128, cache line width in bits (16-byte line; offset bits [3:0] ignored).
DEPTH_LINES, 256, number of lines in the backing array; power of two, >=2.
LATENCY, 4, BUSY cycles between request acceptance and response; must be >=1.

Ports:
clock  input  1  single clock, all logic on rising edge.
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clock).
mem_req_valid  input  1  request present.
mem_req_rw  input  1  1 = write line, 0 = read line.
mem_req_addr  input  ADDR_W  byte address of line.
mem_req_wdata  input  LINE_W  line data for writes.
mem_req_ready  output  1  responder can accept a request this cycle.
mem_resp_valid  output  1  one-cycle response pulse.
mem_resp_rdata  output  LINE_W  read line (reads) or echo of written line (writes).
mem_busy  output  1  high in BUSY or RESP.

Behaviour:
- Line index = mem_req_addr[4 +: log2(DEPTH_LINES)]. Bits [3:0] and bits above the index are ignored, so addresses wrap modulo DEPTH_LINES*16.
- FSM states:
  - IDLE: mem_req_ready=1, mem_busy=0.
  - BUSY: mem_req_ready=0, mem_busy=1.
  - RESP: mem_req_ready=0, mem_busy=1, mem_resp_valid=1.
- Handshake: a request is accepted on a rising edge where mem_req_valid=1 and mem_req_ready=1 (IDLE only).
  - On accept: latch rw, index and wdata; load counter with LATENCY-1; go to BUSY.
  - Inputs are don't-care outside the accept cycle. The requester must hold valid and payload until it sees ready high.
- BUSY: each cycle, if counter==0 do the access and go to RESP; else decrement.
  - Write access: array[index] <= latched wdata; resp_rdata <= latched wdata.
  - Read access: resp_rdata <= array[index].
- RESP: mem_resp_valid is high for exactly one cycle with no backpressure, then IDLE.
- Timing: request accepted at edge of cycle T, BUSY occupies cycles T+1..T+LATENCY, resp_valid is high in cycle T+LATENCY+1, ready returns in cycle T+LATENCY+2. Peak throughput is one request per LATENCY+2 cycles.
- mem_resp_rdata holds its last value outside RESP. Only qualify it with resp_valid.
- Read-after-write to the same index returns the new line. The write commits before the write's RESP cycle.
- Reset (reset==0 at a rising edge) does all of the following:
  - State goes to IDLE, counter goes to 0.
  - Outputs: ready=0 during the reset cycle (ready=1 from the first cycle after reset deasserts), resp_valid=0, busy=0, resp_rdata=0.
  - All array lines are cleared to 0.
- Reset mid-transaction aborts it: no response is issued, and a pending write is not committed.
- A valid request presented during reset is ignored.

Test Plan:
- After reset, read addr 0x0000_0040 (index 4) with LATENCY=4 -> ready drops next cycle, resp_valid high exactly 5 cycles after accept, rdata=0, ready high the following cycle.
- Write addr 0x0000_0020, wdata=0xDEADBEEF_01234567_89ABCDEF_CAFEF00D, then read 0x0000_002C (same line, offset ignored) -> write resp echoes data, read resp returns the identical 128-bit line.
- Wrap: write index 3 via addr 0x0000_0030 value 0x1111..., then read addr 0x0000_1030 (DEPTH_LINES=256) -> returns 0x1111....
- Back-to-back: hold valid across 3 read requests -> exactly 3 accepts spaced 6 cycles apart, 3 resp pulses, no request lost or duplicated.
- Reset mid-BUSY of a write of 0xAAAA... to index 7 -> no resp_valid, busy=0; subsequent read of index 7 returns 0.
- LATENCY=1 build: accept at T -> resp_valid at T+2, ready at T+3; request held during BUSY/RESP is not accepted until ready.
